// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its coefficient loader.
//   - loader state encoding
//   - default coefficient width / tap count
//   - uniq_taps(): beats per upload; also used where fir_filter is instantiated
//   - addr_bits(): address width for a memory of a given depth (minimum 1)
package fir_pkg;

    localparam int COEFF_WIDTH_DEF = 18;
    localparam int NUM_TAPS_DEF    = 64;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_WRITE = 2'd2,
        LD_LOAD  = 2'd3
    } ldr_state_e;

    function automatic int uniq_taps(input int num_taps, input int symmetric);
        return (symmetric != 0) ? num_taps / 2 : num_taps;
    endfunction

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_shadow_ram.sv
// Shadow buffer for one uploaded coefficient set.
// One write port, one registered read port. The storage array is not reset
// (so it maps onto distributed RAM); only the read output register is reset,
// because that register directly drives the filter's coeff_data.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   wr_en_i/addr/data   write port
//   rd_en_i, rd_addr_i  read request; rd_data_o updates on the next edge
//   rd_data_o           registered read data (holds when rd_en_i=0)
module fir_coeff_shadow_ram #(
    parameter int DW    = 18,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for fir_filter.
// Accepts an upload of UNIQ beats into a shadow buffer, checks that 'last'
// lands exactly on the final beat, then writes all NUM_TAPS filter addresses
// (one per cycle while filt_idle=1) and finishes with a one-cycle coeff_ld.
// In symmetric mode the upper half of the tap range is the mirror of the
// uploaded half.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start                              begin an upload (IDLE only)
//   s_coeff_data/valid/last/ready      upload stream
//   filt_idle                          filter idle; gates coefficient writes
//   coeff_data/addr/wr/ld              filter coefficient port (registered)
//   busy, done, error, beat_count      status
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int NUM_TAPS    = NUM_TAPS_DEF,
    parameter int SYMMETRIC   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COEFF_WIDTH-1:0] s_coeff_data,
    input  logic                   s_coeff_valid,
    input  logic                   s_coeff_last,
    output logic                   s_coeff_ready,
    input  logic                   filt_idle,
    output logic [COEFF_WIDTH-1:0] coeff_data,
    output logic [7:0]             coeff_addr,
    output logic                   coeff_wr,
    output logic                   coeff_ld,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             beat_count
);

    localparam int         UNIQ      = uniq_taps(NUM_TAPS, SYMMETRIC);
    localparam int         AW        = addr_bits(UNIQ);
    localparam logic [7:0] LAST_K    = 8'(NUM_TAPS - 1);
    localparam logic [7:0] UNIQ_LAST = 8'(UNIQ - 1);

    ldr_state_e state_q, state_d;
    logic [7:0] beat_count_q, beat_count_d;
    logic       error_q, error_d;
    logic [7:0] k_q, k_d;
    logic       coeff_wr_q, coeff_wr_d;
    logic [7:0] coeff_addr_q, coeff_addr_d;
    logic       coeff_ld_q, coeff_ld_d;
    logic       done_q, done_d;

    logic          buf_we;
    logic          buf_re;
    logic [AW-1:0] buf_wr_addr;
    logic [AW-1:0] buf_rd_addr;

    // Upper half of the tap range reads the mirrored entry; in
    // non-symmetric mode k never exceeds UNIQ_LAST so this is just k.
    assign buf_wr_addr = AW'(beat_count_q);
    assign buf_rd_addr = AW'(((SYMMETRIC != 0) && (k_q > UNIQ_LAST)) ? (LAST_K - k_q) : k_q);

    // The RAM's read register is the coeff_data output register: it is
    // loaded on the same edge that raises coeff_wr for address k.
    fir_coeff_shadow_ram #(
        .DW   (COEFF_WIDTH),
        .DEPTH(UNIQ),
        .AW   (AW)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (buf_we),
        .wr_addr_i(buf_wr_addr),
        .wr_data_i(s_coeff_data),
        .rd_en_i  (buf_re),
        .rd_addr_i(buf_rd_addr),
        .rd_data_o(coeff_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LD_IDLE;
            beat_count_q <= '0;
            error_q      <= 1'b0;
            k_q          <= '0;
            coeff_wr_q   <= 1'b0;
            coeff_addr_q <= '0;
            coeff_ld_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
            error_q      <= error_d;
            k_q          <= k_d;
            coeff_wr_q   <= coeff_wr_d;
            coeff_addr_q <= coeff_addr_d;
            coeff_ld_q   <= coeff_ld_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_count_d = beat_count_q;
        error_d      = error_q;
        k_d          = k_q;
        coeff_wr_d   = 1'b0;
        coeff_addr_d = coeff_addr_q;
        coeff_ld_d   = 1'b0;
        done_d       = coeff_ld_q;   // done trails coeff_ld by one cycle
        buf_we       = 1'b0;
        buf_re       = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d      = LD_FILL;
                    error_d      = 1'b0;
                    beat_count_d = '0;
                    k_d          = '0;
                end
            end
            LD_FILL: begin
                if (s_coeff_valid) begin
                    buf_we       = 1'b1;
                    beat_count_d = beat_count_q + 8'd1;
                    if (beat_count_q == UNIQ_LAST) begin
                        if (s_coeff_last) begin
                            state_d = LD_WRITE;
                        end else begin
                            error_d = 1'b1;
                            state_d = LD_IDLE;
                        end
                    end else if (s_coeff_last) begin
                        error_d = 1'b1;
                        state_d = LD_IDLE;
                    end
                end
            end
            LD_WRITE: begin
                // k only advances when a write is issued, so a stall never
                // skips an address.
                if (filt_idle) begin
                    coeff_wr_d   = 1'b1;
                    coeff_addr_d = k_q;
                    buf_re       = 1'b1;
                    if (k_q == LAST_K) state_d = LD_LOAD;
                    else               k_d     = k_q + 8'd1;
                end
            end
            LD_LOAD: begin
                coeff_ld_d = 1'b1;
                state_d    = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    assign s_coeff_ready = (state_q == LD_FILL);
    assign busy          = (state_q != LD_IDLE);
    assign coeff_wr      = coeff_wr_q;
    assign coeff_addr    = coeff_addr_q;
    assign coeff_ld      = coeff_ld_q;
    assign done          = done_q;
    assign error         = error_q;
    assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

    localparam int CW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_s = 1'b0, start_n = 1'b0;
    logic [CW-1:0] s_data = '0;
    logic          s_valid = 1'b0, s_last = 1'b0, filt_idle = 1'b1;

    logic          rdy_s, wr_s, ld_s, busy_s, done_s, err_s;
    logic [CW-1:0] data_s;
    logic [7:0]    addr_s, bc_s;
    logic          rdy_n, wr_n, ld_n, busy_n, done_n, err_n;
    logic [CW-1:0] data_n;
    logic [7:0]    addr_n, bc_n;

    fir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_TAPS(8), .SYMMETRIC(1)) u_sym (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .s_coeff_data(s_data), .s_coeff_valid(s_valid), .s_coeff_last(s_last),
        .s_coeff_ready(rdy_s), .filt_idle(filt_idle),
        .coeff_data(data_s), .coeff_addr(addr_s), .coeff_wr(wr_s), .coeff_ld(ld_s),
        .busy(busy_s), .done(done_s), .error(err_s), .beat_count(bc_s)
    );

    fir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_TAPS(8), .SYMMETRIC(0)) u_ns (
        .clk(clk), .rst_n(rst_n), .start(start_n),
        .s_coeff_data(s_data), .s_coeff_valid(s_valid), .s_coeff_last(s_last),
        .s_coeff_ready(rdy_n), .filt_idle(filt_idle),
        .coeff_data(data_n), .coeff_addr(addr_n), .coeff_wr(wr_n), .coeff_ld(ld_n),
        .busy(busy_n), .done(done_n), .error(err_n), .beat_count(bc_n)
    );

    // One row per cycle after the last upload beat: inputs (fi, st) and
    // expected coefficient-port outputs sampled after that cycle's edge.
    typedef struct {
        logic          fi;
        logic          st;
        logic          wr;
        logic [7:0]    addr;
        logic [CW-1:0] data;
        logic          ld;
        logic          done;
    } vec_t;

    vec_t tbl[16];
    int   tbl_n;
    int   up_vals[8];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic fi, logic st, logic wr, int addr, int data, logic ld, logic done);
        vec_t v;
        v.fi = fi; v.st = st; v.wr = wr; v.addr = 8'(addr); v.data = CW'(data);
        v.ld = ld; v.done = done;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    // Upload n beats from up_vals; 'last' on beat index last_idx (-1: never).
    // The start cycle also presents a bogus valid beat that must be ignored.
    task automatic upload(input bit sym, input int n, input int last_idx, input bit do_start);
        if (do_start) begin
            if (sym) start_s = 1'b1; else start_n = 1'b1;
            s_valid = 1'b1; s_data = '1; s_last = 1'b0;
            tick();
            start_s = 1'b0; start_n = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = CW'(up_vals[i]);
            s_last  = (i == last_idx);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_table(input bit sym, input string nm);
        logic          g_wr, g_ld, g_done;
        logic [7:0]    g_addr;
        logic [CW-1:0] g_data;
        bit            ok;
        for (int i = 0; i < tbl_n; i++) begin
            filt_idle = tbl[i].fi;
            if (sym) start_s = tbl[i].st; else start_n = tbl[i].st;
            tick();
            start_s = 1'b0; start_n = 1'b0;
            if (sym) begin
                g_wr = wr_s; g_ld = ld_s; g_done = done_s; g_addr = addr_s; g_data = data_s;
            end else begin
                g_wr = wr_n; g_ld = ld_n; g_done = done_n; g_addr = addr_n; g_data = data_n;
            end
            ok = (g_wr === tbl[i].wr) && (g_ld === tbl[i].ld) && (g_done === tbl[i].done) &&
                 (!tbl[i].wr || ((g_addr === tbl[i].addr) && (g_data === tbl[i].data)));
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s row %0d: got wr=%b addr=%0d data=%0d ld=%b done=%b, want wr=%b addr=%0d data=%0d ld=%b done=%b",
                         nm, i, g_wr, g_addr, g_data, g_ld, g_done,
                         tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].ld, tbl[i].done);
            end
        end
        filt_idle = 1'b1;
    endtask

    // Standard no-stall table for a symmetric 8-tap upload with values d[].
    task automatic fill_sym_table(input int d0, input int d1, input int d2, input int d3);
        int d[8];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        d[4] = d3; d[5] = d2; d[6] = d1; d[7] = d0;
        for (int k = 0; k < 8; k++) tbl[k] = mk(1, 0, 1, k, d[k], 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl_n = 11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int guard;

        // ---- reset state ----
        tick();
        check("rst_sym_outs", {rdy_s, wr_s, ld_s, busy_s, done_s, err_s, bc_s, addr_s, data_s}, 64'd0);
        check("rst_ns_outs",  {rdy_n, wr_n, ld_n, busy_n, done_n, err_n, bc_n, addr_n, data_n}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ---- symmetric upload 1,2,3,4 ----
        up_vals[0] = 1; up_vals[1] = 2; up_vals[2] = 3; up_vals[3] = 4;
        upload(1, 4, 3, 1);
        check("sym_busy_after_last", busy_s, 1);
        check("sym_no_wr_on_last",   wr_s, 0);
        fill_sym_table(1, 2, 3, 4);
        run_table(1, "sym_basic");
        check("sym_beat_count", bc_s, 4);
        check("sym_error",      err_s, 0);
        check("sym_idle",       busy_s, 0);

        // ---- non-symmetric upload 10..17 ----
        for (int i = 0; i < 8; i++) up_vals[i] = 10 + i;
        upload(0, 8, 7, 1);
        for (int k = 0; k < 8; k++) tbl[k] = mk(1, 0, 1, k, 10 + k, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl_n = 11;
        run_table(0, "ns_basic");
        check("ns_beat_count", bc_n, 8);

        // ---- stall: filt_idle low 3 cycles after addr 2 ----
        up_vals[0] = 5; up_vals[1] = 6; up_vals[2] = 7; up_vals[3] = 8;
        upload(1, 4, 3, 1);
        tbl[0]  = mk(1, 0, 1, 0, 5, 0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 6, 0, 0);
        tbl[2]  = mk(1, 0, 1, 2, 7, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 3, 8, 0, 0);
        tbl[7]  = mk(1, 0, 1, 4, 8, 0, 0);
        tbl[8]  = mk(1, 0, 1, 5, 7, 0, 0);
        tbl[9]  = mk(1, 0, 1, 6, 6, 0, 0);
        tbl[10] = mk(1, 0, 1, 7, 5, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1);
        tbl_n = 13;
        run_table(1, "sym_stall");

        // ---- start during WRITE is ignored ----
        up_vals[0] = 21; up_vals[1] = 22; up_vals[2] = 23; up_vals[3] = 24;
        upload(1, 4, 3, 1);
        fill_sym_table(21, 22, 23, 24);
        tbl[3].st = 1'b1;
        run_table(1, "sym_start_in_write");
        check("start_in_write_idle", busy_s, 0);

        // ---- short upload: last on beat 3 ----
        up_vals[0] = 31; up_vals[1] = 32; up_vals[2] = 33;
        upload(1, 3, 2, 1);
        check("short_error", err_s, 1);
        check("short_busy",  busy_s, 0);
        check("short_bc",    bc_s, 3);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_s || ld_s || done_s) seen = 1;
        end
        check("short_no_writes", seen, 0);
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("start_clears_error", err_s, 0);
        check("start_clears_bc",    bc_s, 0);
        check("start_enters_fill",  rdy_s, 1);

        // ---- missing last on beat 4 ----
        up_vals[0] = 41; up_vals[1] = 42; up_vals[2] = 43; up_vals[3] = 44;
        upload(1, 4, -1, 0);
        check("nolast_error", err_s, 1);
        check("nolast_busy",  busy_s, 0);
        check("nolast_bc",    bc_s, 4);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = CW'(50 + i); s_last = (i == 3);
            tick();
            if (rdy_s || wr_s || ld_s || busy_s) seen = 1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("idle_valid_ignored", seen, 0);
        check("idle_bc_unchanged",  bc_s, 4);

        // ---- reset in the middle of WRITE (addr 5) ----
        up_vals[0] = 61; up_vals[1] = 62; up_vals[2] = 63; up_vals[3] = 64;
        upload(1, 4, 3, 1);
        guard = 0;
        while (!(wr_s === 1'b1 && addr_s === 8'd5) && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_addr5", guard < 20, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midwrite_rst_outs", {rdy_s, wr_s, ld_s, busy_s, done_s, err_s, bc_s, addr_s, data_s}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_idle", busy_s, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ld_s || wr_s) seen = 1;
        end
        check("post_rst_no_ld", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
